// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg: shared state encoding and sizing constants for the instruction-memory loader.
package imem_loader_pkg;
  typedef enum logic [2:0] {IDLE, LEN, DATA, WRITE, DONE, ERR} loader_state_t;
  localparam int BYTES_PER_WORD = 4;
  localparam int DEPTH_DEFAULT = 64;
endpackage

// File: rtl/imem_loader_if.sv
// imem_loader_if: byte stream, memory write port and core status signals of the loader.
interface imem_loader_if;
  logic start;
  logic rx_valid;
  logic [7:0] rx_data;
  logic rx_ready;
  logic mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wd;
  logic cpu_reset;
  logic done;
  logic error;
  modport master (
    input start, rx_valid, rx_data,
    output rx_ready, mem_we, mem_addr, mem_wd, cpu_reset, done, error
  );
  modport slave (
    output start, rx_valid, rx_data,
    input rx_ready, mem_we, mem_addr, mem_wd, cpu_reset, done, error
  );
endinterface

// File: rtl/imem_loader_byte_packer.sv
// byte_packer: assembles little-endian 32-bit words from accepted bytes; word is valid with the 4th byte.
module byte_packer
  import imem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        clr,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic [31:0] word,
  output logic        word_valid
);
  logic [1:0] cnt;
  logic [23:0] sr;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
      sr <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (in_valid) begin
      cnt <= cnt + 2'd1;
      sr <= {in_data, sr[23:8]};
    end
  end
  // the 4th byte completes the word combinationally, so no extra cycle is spent
  assign word = {in_data, sr};
  assign word_valid = in_valid && cnt == 2'(BYTES_PER_WORD - 1);
endmodule

// File: rtl/imem_loader.sv
// imem_loader: receives a length-prefixed byte stream and writes it into instruction memory,
// holding the core in reset until a complete, valid program has been loaded.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEFAULT
) (
  input logic clk,
  input logic reset_n,
  imem_loader_if.master bus
);
  localparam int IW = $clog2(DEPTH) + 1;
  loader_state_t state, state_nx;
  logic [IW-1:0] idx, n;
  logic [31:0] word;
  logic word_valid, take, idle_like, clr, bad, last;
  assign take = bus.rx_valid && bus.rx_ready;
  assign idle_like = state == IDLE || state == DONE || state == ERR;
  assign clr = bus.start && idle_like;
  assign bad = word == 32'd0 || word > 32'(DEPTH);
  assign last = idx == n - IW'(1);
  byte_packer u_packer (
    .clk(clk),
    .reset_n(reset_n),
    .clr(clr),
    .in_valid(take),
    .in_data(bus.rx_data),
    .word(word),
    .word_valid(word_valid)
  );
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      idx <= '0;
      n <= '0;
      bus.mem_addr <= '0;
      bus.mem_wd <= '0;
    end else begin
      state <= state_nx;
      if (clr) idx <= '0;
      if (state == LEN && word_valid && !bad) n <= word[IW-1:0];
      if (state == DATA && word_valid) begin
        bus.mem_addr <= {{(30-IW){1'b0}}, idx, 2'b00};
        bus.mem_wd <= word;
      end
      if (state == WRITE && !last) idx <= idx + IW'(1);
    end
  end
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE, DONE, ERR: state_nx = bus.start ? LEN : state;
      LEN:             state_nx = word_valid ? (bad ? ERR : DATA) : LEN;
      DATA:            state_nx = word_valid ? WRITE : DATA;
      WRITE:           state_nx = last ? DONE : DATA;
      default:         state_nx = IDLE;
    endcase
    bus.rx_ready = state == LEN || state == DATA;
    bus.mem_we = state == WRITE;
    bus.cpu_reset = state != DONE;
    bus.done = state == DONE;
    bus.error = state == ERR;
  end
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed scenarios for the loader with hand-computed expected writes.
module tb_imem_loader;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int n_checks = 0;
  int n_fail = 0;
  logic [31:0] wa[$];
  logic [31:0] wd[$];
  imem_loader_if bus();
  imem_loader #(.DEPTH(64)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));
  always #5 clk = ~clk;
  always @(negedge clk) if (bus.mem_we) begin
    wa.push_back(bus.mem_addr);
    wd.push_back(bus.mem_wd);
  end

  task automatic send_byte(input logic [7:0] b);
    int t = 0;
    bus.rx_valid = 1'b1;
    bus.rx_data = b;
    while (!bus.rx_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) begin
      n_checks++;
      n_fail++;
      $display("FAIL send_byte timeout: rx_ready stayed %b, required 1", bus.rx_ready);
    end
    @(negedge clk);
    bus.rx_valid = 1'b0;
  endtask

  task automatic send_stream(input logic [7:0] q[$], input int gap);
    foreach (q[i]) begin
      repeat (gap) @(negedge clk);
      send_byte(q[i]);
    end
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic wait_end();
    int t = 0;
    while (!(bus.done || bus.error) && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) begin
      n_checks++;
      n_fail++;
      $display("FAIL wait_end timeout: done=%b error=%b, required one of them 1", bus.done, bus.error);
    end
  endtask

  task automatic test_reset();
    bus.start = 1'b0;
    bus.rx_valid = 1'b0;
    bus.rx_data = 8'h00;
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++; if (bus.cpu_reset !== 1'b1) begin n_fail++; $display("FAIL reset cpu_reset: got %b, required 1", bus.cpu_reset); end
    n_checks++; if (bus.rx_ready !== 1'b0) begin n_fail++; $display("FAIL reset rx_ready: got %b, required 0", bus.rx_ready); end
    n_checks++; if (bus.mem_we !== 1'b0) begin n_fail++; $display("FAIL reset mem_we: got %b, required 0", bus.mem_we); end
    n_checks++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL reset done: got %b, required 0", bus.done); end
    n_checks++; if (bus.error !== 1'b0) begin n_fail++; $display("FAIL reset error: got %b, required 0", bus.error); end
    n_checks++; if (bus.mem_addr !== 32'h0 || bus.mem_wd !== 32'h0) begin n_fail++; $display("FAIL reset mem regs: addr=%h wd=%h, required 0/0", bus.mem_addr, bus.mem_wd); end
    reset_n = 1'b1;
    repeat (5) @(negedge clk);
    n_checks++; if (bus.rx_ready !== 1'b0 || bus.cpu_reset !== 1'b1) begin n_fail++; $display("FAIL idle hold: rx_ready=%b cpu_reset=%b, required 0/1", bus.rx_ready, bus.cpu_reset); end
  endtask

  task automatic check_basic_result(input string tag);
    n_checks++; if (wa.size() !== 2) begin n_fail++; $display("FAIL %s write count: got %0d, required 2", tag, wa.size()); end
    if (wa.size() >= 2) begin
      n_checks++; if (wa[0] !== 32'h0 || wd[0] !== 32'h00A00513) begin n_fail++; $display("FAIL %s word0: addr=%h data=%h, required 0/00a00513", tag, wa[0], wd[0]); end
      n_checks++; if (wa[1] !== 32'h4 || wd[1] !== 32'h00B00593) begin n_fail++; $display("FAIL %s word1: addr=%h data=%h, required 4/00b00593", tag, wa[1], wd[1]); end
    end
    n_checks++; if (bus.done !== 1'b1 || bus.cpu_reset !== 1'b0 || bus.error !== 1'b0) begin n_fail++; $display("FAIL %s status: done=%b cpu_reset=%b error=%b, required 1/0/0", tag, bus.done, bus.cpu_reset, bus.error); end
  endtask

  task automatic test_basic();
    logic [7:0] q[$] = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h13, 8'h05, 8'hA0, 8'h00, 8'h93, 8'h05, 8'hB0, 8'h00};
    wa.delete(); wd.delete();
    bus.rx_valid = 1'b1;
    bus.rx_data = 8'hFF;
    repeat (3) @(negedge clk);
    bus.rx_valid = 1'b0;
    pulse_start();
    n_checks++; if (bus.rx_ready !== 1'b1) begin n_fail++; $display("FAIL basic LEN rx_ready: got %b, required 1", bus.rx_ready); end
    send_stream(q, 0);
    wait_end();
    check_basic_result("basic");
  endtask

  task automatic test_bad_count();
    logic [7:0] q65[$] = '{8'h41, 8'h00, 8'h00, 8'h00};
    logic [7:0] q0[$] = '{8'h00, 8'h00, 8'h00, 8'h00};
    logic [7:0] qok[$] = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12};
    wa.delete(); wd.delete();
    pulse_start();
    send_stream(q65, 0);
    wait_end();
    n_checks++; if (bus.error !== 1'b1 || bus.done !== 1'b0) begin n_fail++; $display("FAIL n65 status: error=%b done=%b, required 1/0", bus.error, bus.done); end
    n_checks++; if (bus.rx_ready !== 1'b0 || bus.cpu_reset !== 1'b1) begin n_fail++; $display("FAIL n65 err outputs: rx_ready=%b cpu_reset=%b, required 0/1", bus.rx_ready, bus.cpu_reset); end
    n_checks++; if (wa.size() !== 0) begin n_fail++; $display("FAIL n65 writes: got %0d, required 0", wa.size()); end
    pulse_start();
    n_checks++; if (bus.error !== 1'b0 || bus.rx_ready !== 1'b1) begin n_fail++; $display("FAIL restart: error=%b rx_ready=%b, required 0/1", bus.error, bus.rx_ready); end
    send_stream(q0, 0);
    wait_end();
    n_checks++; if (bus.error !== 1'b1 || wa.size() !== 0) begin n_fail++; $display("FAIL n0: error=%b writes=%0d, required 1/0", bus.error, wa.size()); end
    pulse_start();
    send_stream(qok, 0);
    wait_end();
    n_checks++; if (wa.size() !== 1) begin n_fail++; $display("FAIL recover write count: got %0d, required 1", wa.size()); end
    if (wa.size() >= 1) begin
      n_checks++; if (wa[0] !== 32'h0 || wd[0] !== 32'h12345678) begin n_fail++; $display("FAIL recover word: addr=%h data=%h, required 0/12345678", wa[0], wd[0]); end
    end
    n_checks++; if (bus.done !== 1'b1 || bus.error !== 1'b0) begin n_fail++; $display("FAIL recover status: done=%b error=%b, required 1/0", bus.done, bus.error); end
  endtask

  task automatic test_backpressure();
    logic [7:0] q[$] = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h13, 8'h05, 8'hA0, 8'h00, 8'h93, 8'h05, 8'hB0, 8'h00};
    wa.delete(); wd.delete();
    pulse_start();
    send_stream(q, 2);
    wait_end();
    check_basic_result("gaps");
  endtask

  task automatic test_midreset();
    logic [7:0] q1[$] = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    logic [7:0] q2[$] = '{8'h01, 8'h00, 8'h00, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    pulse_start();
    send_stream(q1, 0);
    reset_n = 1'b0;
    @(negedge clk);
    n_checks++; if (bus.rx_ready !== 1'b0 || bus.cpu_reset !== 1'b1 || bus.mem_addr !== 32'h0) begin n_fail++; $display("FAIL midreset state: rx_ready=%b cpu_reset=%b addr=%h, required 0/1/0", bus.rx_ready, bus.cpu_reset, bus.mem_addr); end
    reset_n = 1'b1;
    @(negedge clk);
    wa.delete(); wd.delete();
    pulse_start();
    send_stream(q2, 0);
    wait_end();
    n_checks++; if (wa.size() !== 1) begin n_fail++; $display("FAIL midreset write count: got %0d, required 1", wa.size()); end
    if (wa.size() >= 1) begin
      n_checks++; if (wa[0] !== 32'h0 || wd[0] !== 32'hDEADBEEF) begin n_fail++; $display("FAIL midreset word: addr=%h data=%h, required 0/deadbeef", wa[0], wd[0]); end
    end
    n_checks++; if (bus.done !== 1'b1) begin n_fail++; $display("FAIL midreset done: got %b, required 1", bus.done); end
  endtask

  task automatic test_full_depth();
    logic [7:0] q[$];
    logic [31:0] w;
    q = '{8'h40, 8'h00, 8'h00, 8'h00};
    for (int i = 0; i < 64; i++) begin
      w = 32'hA500_0000 + 32'(i);
      for (int k = 0; k < 4; k++) q.push_back(w[8*k +: 8]);
    end
    wa.delete(); wd.delete();
    pulse_start();
    send_stream(q, 0);
    wait_end();
    n_checks++; if (wa.size() !== 64) begin n_fail++; $display("FAIL full write count: got %0d, required 64", wa.size()); end
    for (int i = 0; i < 64 && i < wa.size(); i++) begin
      n_checks++; if (wa[i] !== 32'(i * 4) || wd[i] !== 32'hA500_0000 + 32'(i)) begin n_fail++; $display("FAIL full word%0d: addr=%h data=%h, required %h/%h", i, wa[i], wd[i], 32'(i * 4), 32'hA500_0000 + 32'(i)); end
    end
    n_checks++; if (wa.size() == 0 || wa[wa.size()-1] !== 32'hFC) begin n_fail++; $display("FAIL full last addr: got %0d writes, required last at fc", wa.size()); end
    n_checks++; if (bus.done !== 1'b1 || bus.cpu_reset !== 1'b0) begin n_fail++; $display("FAIL full status: done=%b cpu_reset=%b, required 1/0", bus.done, bus.cpu_reset); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_bad_count();
    test_backpressure();
    test_midreset();
    test_full_depth();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
